// File: rtl/corr_pkg.sv
// Shared correlator constants: bank map, address width and the dump FSM encoding.
// The correlator address decoder imports the same bank bases and lengths.
package corr_pkg;

    localparam int NUM_BANKS = 5;
    localparam int ADDR_W    = 16;
    localparam int OFF_W     = 9;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_HDR   = 4'd1,
        ST_ADDR  = 4'd2,
        ST_WAIT  = 4'd3,
        ST_LATCH = 4'd4,
        ST_SEND  = 4'd5,
        ST_SUM   = 4'd6,
        ST_CLR   = 4'd7,
        ST_DONE  = 4'd8
    } state_t;

    // Bank index 0..4 corresponds to correlator bank 1..5.
    function automatic logic [ADDR_W-1:0] bank_base(input logic [2:0] bank);
        case (bank)
            3'd0:    return 16'h1000;
            3'd1:    return 16'h2000;
            3'd2:    return 16'h3000;
            3'd3:    return 16'h4000;
            3'd4:    return 16'h5000;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [OFF_W:0] bank_len(input logic [2:0] bank);
        case (bank)
            3'd0:    return 10'd32;
            3'd1:    return 10'd64;
            3'd2:    return 10'd128;
            3'd3:    return 10'd256;
            3'd4:    return 10'd512;
            default: return 10'd0;
        endcase
    endfunction

    function automatic logic [7:0] byte_sum(input logic [31:0] word);
        return word[31:24] + word[23:16] + word[15:8] + word[7:0];
    endfunction

endpackage

// File: rtl/corr_word_ser.sv
// Left-aligned word-to-byte serializer with valid/ready handshake, MSB byte first.
// A load takes priority over a shift so a new word can follow the final accept.
module corr_word_ser
    import corr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic [2:0]  load_cnt,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        last_accept
);

    logic [31:0] shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        accept_s;

    assign accept_s    = valid_q & tx_ready;
    assign last_accept = accept_s & (cnt_q == 3'd1);
    assign tx_data     = shift_q[31:24];
    assign tx_valid    = valid_q;

    // Next shift-register contents and remaining byte count.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            shift_d = load_word;
            cnt_d   = load_cnt;
        end else if (accept_s) begin
            shift_d = {shift_q[23:0], 8'h00};
            cnt_d   = cnt_q - 3'd1;
        end else begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
        end
        valid_d = (cnt_d != 3'd0);
    end

    // Serializer state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= 32'h0000_0000;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/corr_dump_reader.sv
// Correlator result dump: sweeps five result banks and streams them to the host
// as a framed byte stream (two sync bytes, payload MSB-first, 8-bit checksum).
module corr_dump_reader
    import corr_pkg::*;
#(
    parameter int         READ_LAT = 1,
    parameter logic [7:0] SYNC0    = 8'hA5,
    parameter logic [7:0] SYNC1    = 8'h5A
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clrAfter,
    output logic              busy,
    output logic              done,
    output logic              read,
    output logic [ADDR_W-1:0] RamAddr,
    input  logic [31:0]       RamData,
    output logic              corrClr,
    output logic [7:0]        txData,
    output logic              txValid,
    input  logic              txReady
);

    localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 2);

    state_t             state_q, state_d;
    logic [2:0]         bank_q, bank_d;
    logic [OFF_W-1:0]   offset_q, offset_d;
    logic [1:0]         wait_q, wait_d;
    logic [31:0]        hold_q, hold_d;
    logic [7:0]         csum_q, csum_d;
    logic               clr_q, clr_d;
    logic               busy_q, busy_d, done_q, done_d, read_q, read_d, corr_clr_q, corr_clr_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic               ser_load_s, ser_last_s, last_off_s;
    logic [31:0]        ser_word_s;
    logic [2:0]         ser_cnt_s;

    assign last_off_s = ({1'b0, offset_q} == (bank_len(bank_q) - 10'd1));

    corr_word_ser u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (ser_load_s),
        .load_word   (ser_word_s),
        .load_cnt    (ser_cnt_s),
        .tx_ready    (txReady),
        .tx_data     (txData),
        .tx_valid    (txValid),
        .last_accept (ser_last_s)
    );

    // Next-state and datapath: bank/offset sweep, read latency wait, checksum.
    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        offset_d   = offset_q;
        wait_d     = wait_q;
        hold_d     = hold_q;
        csum_d     = csum_q;
        clr_d      = clr_q;
        ser_load_s = 1'b0;
        ser_word_s = 32'h0000_0000;
        ser_cnt_s  = 3'd0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_HDR;
                    clr_d      = clrAfter;
                    bank_d     = 3'd0;
                    offset_d   = '0;
                    csum_d     = 8'h00;
                    ser_load_s = 1'b1;
                    ser_word_s = {SYNC0, SYNC1, 16'h0000};
                    ser_cnt_s  = 3'd2;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (ser_last_s) begin
                    state_d  = ST_ADDR;
                    bank_d   = 3'd0;
                    offset_d = '0;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_ADDR: begin
                wait_d  = 2'd0;
                state_d = (READ_LAT == 1) ? ST_LATCH : ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_LATCH;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_LATCH: begin
                hold_d     = RamData;
                ser_load_s = 1'b1;
                ser_word_s = RamData;
                ser_cnt_s  = 3'd4;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (ser_last_s) begin
                    csum_d = csum_q + byte_sum(hold_q);
                    if (!last_off_s) begin
                        offset_d = offset_q + 9'd1;
                        state_d  = ST_ADDR;
                    end else if (bank_q < 3'(NUM_BANKS - 1)) begin
                        bank_d   = bank_q + 3'd1;
                        offset_d = '0;
                        state_d  = ST_ADDR;
                    end else begin
                        // Last word done: the checksum byte follows without a gap.
                        state_d    = ST_SUM;
                        ser_load_s = 1'b1;
                        ser_word_s = {csum_d, 24'h00_0000};
                        ser_cnt_s  = 3'd1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_SUM: begin
                if (ser_last_s) begin
                    state_d = clr_q ? ST_CLR : ST_DONE;
                end else begin
                    state_d = ST_SUM;
                end
            end
            ST_CLR:  state_d = ST_DONE;
            ST_DONE: begin
                state_d = ST_IDLE;
                clr_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they register in step with state_q.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        corr_clr_d = (state_d == ST_CLR);
        if (state_d inside {ST_ADDR, ST_WAIT, ST_LATCH}) begin
            read_d     = 1'b1;
            ram_addr_d = bank_base(bank_d) + {7'd0, offset_d};
        end else begin
            read_d     = 1'b0;
            ram_addr_d = 16'h0000;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bank_q     <= 3'd0;
            offset_q   <= '0;
            wait_q     <= 2'd0;
            hold_q     <= 32'h0000_0000;
            csum_q     <= 8'h00;
            clr_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            read_q     <= 1'b0;
            corr_clr_q <= 1'b0;
            ram_addr_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            offset_q   <= offset_d;
            wait_q     <= wait_d;
            hold_q     <= hold_d;
            csum_q     <= csum_d;
            clr_q      <= clr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            read_q     <= read_d;
            corr_clr_q <= corr_clr_d;
            ram_addr_q <= ram_addr_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign read    = read_q;
    assign corrClr = corr_clr_q;
    assign RamAddr = ram_addr_q;

endmodule

// File: tb/tb_corr_dump_reader.sv
// Scoreboard bench for corr_dump_reader: randomized txReady/start stimulus,
// expected frames built from the bank map, monitor pops and compares each byte.
module tb_corr_dump_reader;

    localparam int RL = 3;

    logic        clk = 1'b0;
    logic        rst_n, start, clrAfter, txReady;
    logic        busy, done, read, corrClr, txValid;
    logic [15:0] RamAddr;
    logic [31:0] RamData;
    logic [7:0]  txData;

    always #5 clk = ~clk;

    corr_dump_reader #(.READ_LAT(RL), .SYNC0(8'hA5), .SYNC1(8'h5A)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .clrAfter (clrAfter),
        .busy     (busy),
        .done     (done),
        .read     (read),
        .RamAddr  (RamAddr),
        .RamData  (RamData),
        .corrClr  (corrClr),
        .txData   (txData),
        .txValid  (txValid),
        .txReady  (txReady)
    );

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q[$];
    int          cyc = 0, total_bytes = 0, total_clr = 0, total_done = 0;
    int          last_acc_cyc = 0, clr_cyc = 0, done_cyc = 0, run_len = 0, max_run = 0;
    bit          mode1 = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    function automatic logic [31:0] ram_word(input logic [15:0] a, input bit m);
        return m ? 32'h0101_0101 : {16'h0000, a};
    endfunction

    // Correlator port model: data valid for exactly one cycle, RL cycles after the read request.
    logic [31:0] pd[4];
    bit          pv[4];
    bit          read_d1;
    always @(posedge clk) begin
        read_d1 <= read;
        pv[0]   <= read && !read_d1;
        pd[0]   <= ram_word(RamAddr, mode1);
        for (int i = 1; i < 4; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end
    assign RamData = pv[RL-1] ? pd[RL-1] : 32'hDEAD_BEEF;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic build_expected(input bit m);
        logic [7:0]  sum;
        logic [31:0] w;
        logic [15:0] a;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        sum = 8'h00;
        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < (32 << (k - 1)); i++) begin
                a = 16'(32'h1000 * k + i);
                w = ram_word(a, m);
                for (int b = 3; b >= 0; b--) begin
                    exp_q.push_back(w[8*b +: 8]);
                    sum = sum + w[8*b +: 8];
                end
            end
        end
        exp_q.push_back(sum);
    endtask

    task automatic run_frame(input bit clr, input bit m, input int pct, input bit extra);
        int b0, c0, d0;
        bit finished;
        mode1 = m;
        build_expected(m);
        b0 = total_bytes; c0 = total_clr; d0 = total_done;
        @(posedge clk); #1;
        start = 1'b1; clrAfter = clr; txReady = ($urandom_range(99) < pct);
        @(posedge clk); #1;
        start = 1'b0; clrAfter = 1'b0;
        finished = 1'b0;
        for (int n = 0; n < 40000 && !finished; n++) begin
            txReady = ($urandom_range(99) < pct);
            start   = 1'b0;
            if (extra && busy && (done || $urandom_range(49) == 0)) start = 1'b1;
            if (total_done != d0) finished = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        check(finished, "frame_timeout", {31'd0, finished}, 32'd1);
        txReady = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check(total_bytes - b0 == 3971, "frame_len", total_bytes - b0, 32'd3971);
        check(total_done - d0 == 1, "done_count", total_done - d0, 32'd1);
        check(total_clr - c0 == int'(clr), "clr_count", total_clr - c0, {31'd0, clr});
        check(exp_q.size() == 0, "bytes_missing", exp_q.size(), 32'd0);
        check(busy == 1'b0, "idle_busy", {31'd0, busy}, 32'd0);
        if (clr) begin
            check(clr_cyc == last_acc_cyc + 1, "clr_timing", clr_cyc - last_acc_cyc, 32'd1);
            check(done_cyc == clr_cyc + 1, "done_after_clr", done_cyc - clr_cyc, 32'd1);
        end else begin
            check(done_cyc == last_acc_cyc + 1, "done_timing", done_cyc - last_acc_cyc, 32'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; clrAfter = 1'b0; txReady = 1'b0;

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (rst_n) begin
                    if (prev_stall)
                        check(txValid && txData == prev_data, "hold_stable", {23'd0, txValid, txData}, {24'd1, prev_data});
                    prev_stall = txValid && !txReady;
                    prev_data  = txData;
                    if (txValid && txReady) begin
                        total_bytes++;
                        last_acc_cyc = cyc;
                        run_len++;
                        if (run_len > max_run) max_run = run_len;
                        if (exp_q.size() == 0) check(1'b0, "extra_byte", {24'd0, txData}, 32'd0);
                        else begin
                            logic [7:0] e;
                            e = exp_q.pop_front();
                            check(txData == e, "byte", {24'd0, txData}, {24'd0, e});
                        end
                    end else begin
                        run_len = 0;
                    end
                    if (corrClr) begin total_clr++; clr_cyc = cyc; end
                    if (done) begin total_done++; done_cyc = cyc; end
                end else begin
                    prev_stall = 1'b0;
                    run_len = 0;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check(busy == 1'b0, "rst_busy", {31'd0, busy}, 32'd0);
        check(done == 1'b0, "rst_done", {31'd0, done}, 32'd0);
        check(read == 1'b0, "rst_read", {31'd0, read}, 32'd0);
        check(corrClr == 1'b0, "rst_clr", {31'd0, corrClr}, 32'd0);
        check(txValid == 1'b0, "rst_txvalid", {31'd0, txValid}, 32'd0);
        check(RamAddr == 16'h0, "rst_addr", {16'd0, RamAddr}, 32'd0);
        check(txData == 8'h0, "rst_txdata", {24'd0, txData}, 32'd0);
        rst_n = 1'b1;

        run_frame(1'b0, 1'b0, 100, 1'b0);
        check(max_run >= 4, "back_to_back", max_run, 32'd4);
        run_frame(1'b1, 1'b0, 30, 1'b1);
        run_frame(1'b0, 1'b1, 50, 1'b0);

        // Abort during bank 3, then a fresh frame must start from the sync bytes.
        begin
            int  c0;
            bit  hit;
            mode1 = 1'b0;
            build_expected(1'b0);
            c0 = total_clr;
            @(posedge clk); #1;
            start = 1'b1; clrAfter = 1'b1; txReady = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; clrAfter = 1'b0;
            hit = 1'b0;
            for (int n = 0; n < 20000 && !hit; n++) begin
                if (RamAddr[15:12] == 4'h3) hit = 1'b1;
                else begin
                    @(posedge clk); #1;
                end
            end
            check(hit, "reach_bank3", {31'd0, hit}, 32'd1);
            rst_n = 1'b0;
            @(posedge clk); #1;
            check(busy == 1'b0, "abort_busy", {31'd0, busy}, 32'd0);
            check(read == 1'b0, "abort_read", {31'd0, read}, 32'd0);
            check(txValid == 1'b0, "abort_txvalid", {31'd0, txValid}, 32'd0);
            check(corrClr == 1'b0, "abort_clr", {31'd0, corrClr}, 32'd0);
            check(RamAddr == 16'h0, "abort_addr", {16'd0, RamAddr}, 32'd0);
            exp_q.delete();
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            check(total_clr == c0, "abort_no_clr_pulse", total_clr - c0, 32'd0);
            run_frame(1'b0, 1'b0, 100, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
